// File: rtl/cdc_hs_responder_pkg.sv
// Shared definitions for the req/ack handshake responder.
package cdc_hs_responder_pkg;

    localparam int HS_STATE_W = 2;

    typedef enum logic [HS_STATE_W-1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } hs_state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit level synchronizer into dst_clk. The chain depth is never allowed
// below two flops, whatever value the instantiating module passes in.
module cdc_sync_bit #(
    parameter int pSYNC_STAGES = 2
) (
    input  logic dst_clk,
    input  logic reset_i,
    input  logic d,
    output logic q
);

    localparam int STAGES = (pSYNC_STAGES < 2) ? 2 : pSYNC_STAGES;

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    // shift the asynchronous level through the metastability chain
    always_ff @(posedge dst_clk or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_responder.sv
// Destination endpoint of a 4-phase req/ack level handshake. Captures the
// remote word once the synchronized request is seen, offers it on valid/ready,
// and raises ack only after the consumer takes it.
//
// state | meaning
// IDLE  | ack low, waiting for a synchronized request
// HOLD  | word captured, dst_valid high until the consumer accepts
// ACK   | ack high, waiting for the remote side to drop req
module cdc_hs_responder
    import cdc_hs_responder_pkg::*;
#(
    parameter int pDATA_WIDTH  = 8,
    parameter int pSYNC_STAGES = 2,
    parameter int pCOUNT_WIDTH = 16
) (
    input  logic                    dst_clk,
    input  logic                    reset_i,
    input  logic                    async_req_i,
    input  logic [pDATA_WIDTH-1:0]  async_data_i,
    output logic                    async_ack_o,
    output logic                    dst_valid,
    input  logic                    dst_ready,
    output logic [pDATA_WIDTH-1:0]  dst_data,
    output logic [pCOUNT_WIDTH-1:0] dst_count,
    output logic                    proto_err
);

    hs_state_e               state, state_nxt;
    logic                    req_s;
    logic                    ack_nxt;
    logic                    valid_nxt;
    logic [pDATA_WIDTH-1:0]  data_nxt;
    logic [pCOUNT_WIDTH-1:0] count_nxt;
    logic                    err_nxt;

    cdc_sync_bit #(
        .pSYNC_STAGES (pSYNC_STAGES)
    ) u_req_sync (
        .dst_clk (dst_clk),
        .reset_i (reset_i),
        .d       (async_req_i),
        .q       (req_s)
    );

    // state and every output are registered so ack leaves straight from a flop
    always_ff @(posedge dst_clk or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            async_ack_o <= 1'b0;
            dst_valid   <= 1'b0;
            dst_data    <= '0;
            dst_count   <= '0;
            proto_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            async_ack_o <= ack_nxt;
            dst_valid   <= valid_nxt;
            dst_data    <= data_nxt;
            dst_count   <= count_nxt;
            proto_err   <= err_nxt;
        end
    end

    // next-state and next-output decode
    always_comb begin
        state_nxt = state;
        ack_nxt   = async_ack_o;
        valid_nxt = dst_valid;
        data_nxt  = dst_data;
        count_nxt = dst_count;
        err_nxt   = proto_err;
        case (state)
            IDLE: begin
                // async_data_i is stable by contract once req_s is high
                if (req_s) begin
                    data_nxt  = async_data_i;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // req dropping early is flagged, but the word still completes
                if (!req_s) begin
                    err_nxt = 1'b1;
                end
                if (dst_ready) begin
                    valid_nxt = 1'b0;
                    ack_nxt   = 1'b1;
                    count_nxt = dst_count + pCOUNT_WIDTH'(1);
                    state_nxt = ACK;
                end
            end
            ACK: begin
                // must see req low here before IDLE can accept a new word
                if (!req_s) begin
                    ack_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                ack_nxt   = 1'b0;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cdc_hs_responder.sv
// Directed bench for cdc_hs_responder. A second instance with a 4-bit counter
// shares all inputs so the counter wrap can be reached in a few transfers.
module tb_cdc_hs_responder;

    logic        dst_clk;
    logic        reset_i;
    logic        async_req_i;
    logic [7:0]  async_data_i;
    logic        dst_ready;
    logic        async_ack_o;
    logic        dst_valid;
    logic [7:0]  dst_data;
    logic [15:0] dst_count;
    logic        proto_err;

    logic        w_ack;
    logic        w_valid;
    logic [7:0]  w_data;
    logic [3:0]  w_count;
    logic        w_err;

    int tests_run = 0;
    int tests_fail = 0;
    logic [7:0] acc_q[$];

    cdc_hs_responder u_dut (
        .dst_clk      (dst_clk),
        .reset_i      (reset_i),
        .async_req_i  (async_req_i),
        .async_data_i (async_data_i),
        .async_ack_o  (async_ack_o),
        .dst_valid    (dst_valid),
        .dst_ready    (dst_ready),
        .dst_data     (dst_data),
        .dst_count    (dst_count),
        .proto_err    (proto_err)
    );

    cdc_hs_responder #(
        .pCOUNT_WIDTH (4)
    ) u_dut_wrap (
        .dst_clk      (dst_clk),
        .reset_i      (reset_i),
        .async_req_i  (async_req_i),
        .async_data_i (async_data_i),
        .async_ack_o  (w_ack),
        .dst_valid    (w_valid),
        .dst_ready    (dst_ready),
        .dst_data     (w_data),
        .dst_count    (w_count),
        .proto_err    (w_err)
    );

    initial dst_clk = 1'b0;
    always #5 dst_clk = ~dst_clk;

    // log every word the consumer actually takes
    always @(posedge dst_clk) begin
        if (!reset_i && dst_valid && dst_ready) acc_q.push_back(dst_data);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge dst_clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag);
        int budget = 10;
        while (!dst_valid && budget > 0) begin
            tick();
            budget--;
        end
        if (!dst_valid) chk({tag, "_valid_timeout"}, 0, 1);
    endtask

    task automatic wait_ack_low(input string tag);
        int budget = 10;
        while (async_ack_o && budget > 0) begin
            tick();
            budget--;
        end
        if (async_ack_o) chk({tag, "_ack_low_timeout"}, 1, 0);
    endtask

    // full 4-phase handshake with the consumer always ready
    task automatic do_transfer(input logic [7:0] d, input string tag);
        async_data_i = d;
        async_req_i  = 1'b1;
        wait_valid(tag);
        chk({tag, "_data"}, dst_data, d);
        tick();
        chk({tag, "_ack_rise"}, async_ack_o, 1);
        async_req_i = 1'b0;
        wait_ack_low(tag);
    endtask

    task automatic do_reset();
        #3 reset_i = 1'b1;
        #4 reset_i = 1'b0;
        tick();
    endtask

    initial begin
        reset_i      = 1'b1;
        async_req_i  = 1'b0;
        async_data_i = 8'h00;
        dst_ready    = 1'b1;
        #12;
        chk("rst_ack", async_ack_o, 0);
        chk("rst_valid", dst_valid, 0);
        chk("rst_data", dst_data, 0);
        chk("rst_count", dst_count, 0);
        chk("rst_err", proto_err, 0);
        #4 reset_i = 1'b0;
        tick();

        // basic transfer: valid on edge 3, accept edge 4, ack low 3 edges after req drops
        async_data_i = 8'hA5;
        async_req_i  = 1'b1;
        tick(2);
        chk("basic_valid_e2", dst_valid, 0);
        tick();
        chk("basic_valid_e3", dst_valid, 1);
        chk("basic_data", dst_data, 8'hA5);
        tick();
        chk("basic_ack", async_ack_o, 1);
        chk("basic_valid_drop", dst_valid, 0);
        chk("basic_count", dst_count, 1);
        async_req_i = 1'b0;
        tick(2);
        chk("basic_ack_hold_e2", async_ack_o, 1);
        tick();
        chk("basic_ack_fall_e3", async_ack_o, 0);

        // backpressure
        dst_ready    = 1'b0;
        async_data_i = 8'h3C;
        async_req_i  = 1'b1;
        tick(3);
        chk("bp_valid", dst_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", dst_valid, 1);
            chk("bp_hold_data", dst_data, 8'h3C);
            chk("bp_hold_ack", async_ack_o, 0);
        end
        dst_ready = 1'b1;
        tick();
        chk("bp_ack", async_ack_o, 1);
        chk("bp_valid_drop", dst_valid, 0);
        chk("bp_count", dst_count, 2);
        async_req_i = 1'b0;
        wait_ack_low("bp");

        // back-to-back 1..16, also drives the 4-bit counter through its wrap
        do_reset();
        acc_q.delete();
        for (int i = 1; i <= 16; i++) begin
            do_transfer(8'(i), "b2b");
            if (i == 15) chk("wrap_pre", w_count, 4'hF);
        end
        chk("wrap_zero", w_count, 4'h0);
        chk("b2b_count", dst_count, 16);
        chk("b2b_err", proto_err, 0);
        chk("b2b_words", acc_q.size(), 16);
        for (int i = 0; i < acc_q.size(); i++) chk("b2b_order", acc_q[i], i + 1);

        // protocol violation: req drops while held
        acc_q.delete();
        dst_ready    = 1'b0;
        async_data_i = 8'h5A;
        async_req_i  = 1'b1;
        wait_valid("viol");
        async_req_i = 1'b0;
        tick(2);
        chk("viol_err_e2", proto_err, 0);
        tick();
        chk("viol_err_e3", proto_err, 1);
        chk("viol_still_valid", dst_valid, 1);
        dst_ready = 1'b1;
        tick();
        chk("viol_ack", async_ack_o, 1);
        chk("viol_valid_drop", dst_valid, 0);
        tick();
        chk("viol_ack_fall", async_ack_o, 0);
        tick(4);
        chk("viol_once", acc_q.size(), 1);
        do_transfer(8'h77, "post_viol");
        chk("viol_sticky", proto_err, 1);
        chk("viol_count", dst_count, 18);

        // reset in HOLD, req left high across release
        dst_ready    = 1'b0;
        async_data_i = 8'hC3;
        async_req_i  = 1'b1;
        wait_valid("rmid");
        #3 reset_i = 1'b1;
        #1;
        chk("rmid_valid", dst_valid, 0);
        chk("rmid_err", proto_err, 0);
        chk("rmid_count", dst_count, 0);
        chk("rmid_ack", async_ack_o, 0);
        @(negedge dst_clk);
        reset_i = 1'b0;
        tick(2);
        chk("rmid_valid_e2", dst_valid, 0);
        tick();
        chk("rmid_valid_e3", dst_valid, 1);
        chk("rmid_data", dst_data, 8'hC3);

        // reset while ack is high drops it without an edge
        dst_ready = 1'b1;
        tick();
        chk("rack_ack_high", async_ack_o, 1);
        #3 reset_i = 1'b1;
        #1;
        chk("rack_ack_async", async_ack_o, 0);
        async_req_i = 1'b0;
        @(negedge dst_clk);
        reset_i = 1'b0;
        tick(5);
        chk("rack_idle_valid", dst_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
